seq_divider: RTL and testbench

Sequential unsigned divider using restoring shift-subtract, one quotient bit per clock. It is the inverse companion to the team's sequential multiplier: a 2·WIDTH-bit product-sized dividend is divided by a WIDTH-bit divisor. It uses the same start/done handshake and holds its last result on the outputs until the next accepted start. It sits beside the multiplier in the arithmetic lab datapath.

---
 rtl/seq_divider.sv | 112 +++++++++++
 tb/tb_seq_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIV_ZERO_CHECK_EN short-circuits a zero divisor to a flagged result after one cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2*WIDTH-1);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     rem;
  logic [CW-1:0]        count;

  logic [WIDTH:0]       shifted;
  logic                 fits;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     next_rem;
  logic [2*WIDTH-1:0]   next_shift;

  // The WIDTH+1-bit partial remainder only exists between shift and compare;
  // the stored remainder is always < divisor, so WIDTH bits hold it.
  always_comb begin
    shifted    = {rem, shift_reg[2*WIDTH-1]};
    fits       = shifted >= {1'b0, dvs};
    diff       = shifted[WIDTH-1:0] - dvs;
    next_rem   = shifted[WIDTH-1:0];
    next_shift = {shift_reg[2*WIDTH-2:0], 1'b0};
    if (fits) begin
      next_rem      = diff;
      next_shift[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      shift_reg <= '0;
      dvs       <= '0;
      rem       <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            shift_reg <= dividend;
            dvs       <= divisor;
            rem       <= '0;
            count     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= BUSY;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
        BUSY: begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
          if (dvs == '0) begin
            quotient    <= '1;
            remainder   <= shift_reg[WIDTH-1:0];
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= FINISH;
          end else
`endif
          begin
            shift_reg <= next_shift;
            rem       <= next_rem;
            count     <= count + 1'b1;
            if (count == LAST) begin
              quotient  <= next_shift;
              remainder <= next_rem;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= FINISH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_DIV_ZERO_CHECK_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results come from integer / and %, checked by a done-edge monitor.
module tb_seq_divider;

  localparam int WIDTH = 8;
`ifdef SEQ_DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic                clk;
  logic                clear;
  logic                start;
  logic [2*WIDTH-1:0]  dividend;
  logic [WIDTH-1:0]    divisor;
  logic [2*WIDTH-1:0]  quotient;
  logic [WIDTH-1:0]    remainder;
  logic                busy;
  logic                done;
  logic                div_by_zero;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [2*WIDTH-1:0] q;
    logic [WIDTH-1:0]   r;
    logic               dbz;
    int                 due;
  } exp_t;

  exp_t               exp_q[$];
  int                 checks = 0;
  int                 failures = 0;
  int                 cycle = 0;
  logic [2*WIDTH-1:0] last_q = '0;
  logic [WIDTH-1:0]   last_r = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic exp_t model(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int now);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a[WIDTH-1:0];
      e.dbz = ZCHK;
      e.due = now + (ZCHK ? 1 : 2*WIDTH);
    end else begin
      e.q   = a / b;
      e.r   = WIDTH'(a % b);
      e.dbz = 1'b0;
      e.due = now + 2*WIDTH;
    end
    return e;
  endfunction

  // Called just after a falling edge; drives one start cycle.
  task automatic applyStimulus(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit accept);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (accept) exp_q.push_back(model(a, b, cycle));
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic waitDone(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done && !busy) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: pops on each rising done, checks hold while busy.
  initial begin : monitor
    bit   prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("quotient", 32'(quotient), 32'(e.q));
          checkOutput("remainder", 32'(remainder), 32'(e.r));
          checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          checkOutput("latency", 32'(cycle), 32'(e.due));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          last_q = e.q;
          last_r = e.r;
        end
      end else if (busy) begin
        checkOutput("hold_quotient", 32'(quotient), 32'(last_q));
        checkOutput("hold_remainder", 32'(remainder), 32'(last_r));
      end
      prev_done = done;
    end
  end

  initial begin : stimulus
    logic [2*WIDTH-1:0] a;
    logic [WIDTH-1:0]   b;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);

    applyStimulus(16'd1000, 8'd7, 1'b1);   waitDone(40);
    applyStimulus(16'hFFFF, 8'hFF, 1'b1);  waitDone(40);
    applyStimulus(16'd5, 8'd9, 1'b1);      waitDone(40);
    applyStimulus(16'd0, 8'd1, 1'b1);      waitDone(40);

    // start while busy must be ignored
    applyStimulus(16'd1000, 8'd7, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(16'd50, 8'd5, 1'b0);
    waitDone(40);
    repeat (3) @(negedge clk);

    // clear in the middle of an operation
    applyStimulus(16'd1000, 8'd7, 1'b1);
    repeat (8) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_q.delete();
    last_q = '0;
    last_r = '0;
    checkOutput("clear_quotient", 32'(quotient), 32'd0);
    checkOutput("clear_remainder", 32'(remainder), 32'd0);
    checkOutput("clear_busy", 32'(busy), 32'd0);
    checkOutput("clear_done", 32'(done), 32'd0);
    checkOutput("clear_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    applyStimulus(16'd40, 8'd3, 1'b1);     waitDone(40);

    // back-to-back start in the first done cycle
    applyStimulus(16'd1000, 8'd7, 1'b1);   waitDone(40);
    applyStimulus(16'd100, 8'd10, 1'b1);   waitDone(40);

    applyStimulus(16'h1234, 8'd0, 1'b1);   waitDone(40);

    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 8'd0;
        1:       b = 8'($urandom_range(1, 3));
        default: b = 8'($urandom_range(1, 255));
      endcase
      applyStimulus(a, b, 1'b1);
      waitDone(40);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checkOutput("pending_results", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
